fifo_level: RTL and testbench
=============================

Name: fifo_level

Overview:
Parametrised successor to the basic synchronous FIFO used across the IMT subsystem. It adds:
- non-power-of-two depth;
- an optional first-word-fall-through bypass;
- push-while-full when a pop happens in the same cycle;
- a fill-level output;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags.

It sits between register-interface producers and consumers wherever flow-control watermarks are needed.

Parameters:
- DATA_WIDTH, 64, width of one entry.
- DEPTH, 8, number of entries; legal range is 2 to 256, any value.
- FALL_THROUGH, 0, when 1 an empty FIFO forwards data_i to data_o in the same cycle.
- data_t, logic [DATA_WIDTH-1:0], entry type.
- CntWidth, $clog2(DEPTH+1), derived localparam, width of the level and threshold signals.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush_i  in  1  synchronous clear of pointers, level and error flags
- push_i  in  1  write request
- data_i  in  data_t  write data
- pop_i  in  1  read request
- data_o  out  data_t  head entry
- full_o  out  1  level == DEPTH
- empty_o  out  1  level == 0
- level_o  out  CntWidth  number of stored entries
- af_thresh_i  in  CntWidth  almost-full threshold
- ae_thresh_i  in  CntWidth  almost-empty threshold
- almost_full_o  out  1  level_o >= af_thresh_i
- almost_empty_o  out  1  level_o <= ae_thresh_i
- clr_err_i  in  1  clears the sticky error flags
- overflow_o  out  1  sticky: a push was refused
- underflow_o  out  1  sticky: a pop was refused

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Pointers, level and error flags are 0, so empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
  - data_o is '0.
  - almost_full_o and almost_empty_o follow their combinational definitions from level 0.
  - The storage array is reset to '0.
- Accept rules (all combinational on the current state):
  - bypass = FALL_THROUGH && empty && push_i && pop_i.
  - push_acc = push_i && !flush_i && (!full || pop_i).
  - pop_acc = pop_i && !flush_i && (!empty || bypass).
- Storage and pointers:
  - On push_acc without bypass: store data_i at wr_ptr and advance wr_ptr.
  - On pop_acc without bypass: advance rd_ptr.
  - A bypass moves neither pointer and stores nothing.
  - Pointers wrap from DEPTH-1 to 0. This must be correct for non-power-of-two DEPTH.
- Level:
  - level_d = level_q + push_acc - pop_acc, with bypass counting as neither.
  - Push and pop in the same cycle leave the level unchanged.
  - The level never exceeds DEPTH and never goes below 0.
- Output data:
  - When not empty: data_o = mem[rd_ptr].
  - When empty and FALL_THROUGH=1 and push_i: data_o = data_i.
  - Otherwise when empty: data_o = '0.
- Latency:
  - FALL_THROUGH=0: a write becomes visible on data_o one cycle after it is accepted.
  - FALL_THROUGH=1: a write into an empty FIFO is visible in the same cycle.
- Full with pop:
  - Push while full is accepted only together with a pop.
  - The write lands in the slot just freed, and full_o stays 1.
- Error flags:
  - overflow_o is set on the cycle after push_i && !push_acc && !flush_i.
  - underflow_o is set on the cycle after pop_i && !pop_acc && !flush_i.
  - Both flags hold until flush_i or clr_err_i.
  - A set and a clear in the same cycle: the clear wins.
- Flush:
  - Highest priority. Next cycle: pointers, level and error flags are 0.
  - Storage contents are not cleared.
  - Push and pop in the flush cycle are dropped and raise no error.
- Thresholds:
  - almost_full_o and almost_empty_o are combinational from the registered level and the live threshold inputs. There is no hysteresis.
  - af_thresh_i=0 forces almost_full_o=1.
  - ae_thresh_i>=DEPTH forces almost_empty_o=1.

Decomposition:
- The shared package imt_fifo_pkg holds:
  - the function cnt_width(depth), returning $clog2(depth+1);
  - a typedef for the fifo status struct {full, empty, almost_full, almost_empty, overflow, underflow}, for reuse by wrappers.
- One sub-module, fifo_wrap_ptr:
  - parameter DEPTH;
  - inputs clk, rst_n, clr_i, inc_i;
  - output ptr_o;
  - a modulo-DEPTH counter, instantiated twice, once for the read pointer and once for the write pointer.
- The storage registers use the codebase's standard flop macros.

Test Plan:
1. DEPTH=5, FALL_THROUGH=0. Push 0x11..0x55 on five cycles, then push 0x66. Required: full_o=1, level_o=5, overflow_o=1 on the next cycle. Pops then return 0x11..0x55 in order and empty_o=1 afterwards.
2. Wrap-around, DEPTH=5. Run 12 cycles of push and pop together starting at level 2. Required: data stays in order across the pointer wrap and level_o stays at 2 throughout.
3. Full plus simultaneous push and pop, DEPTH=5 filled with 1..5. Push 6 and pop together. Required: data_o presents 1 and then 2, full_o stays 1, no overflow. After five more pops the data read is 2,3,4,5,6.
4. FALL_THROUGH=1, empty FIFO. push_i=1 with data 0xAB. Required: data_o=0xAB in the same cycle. With pop_i=1 in that cycle: level_o stays 0 and no underflow. Pop on empty without push: underflow_o=1 on the next cycle, then clr_err_i=1 gives 0.
5. Thresholds, DEPTH=8, af=6, ae=2. Fill from 0 to 8 entries. Required:
   - almost_empty_o=1 for levels 0..2;
   - almost_full_o rises when the level reaches 6;
   - af_thresh_i=0 makes almost_full_o=1 at level 0.
6. Flush and reset mid-operation at level 4 with overflow_o set:
   - flush_i together with push_i: next cycle level_o=0, empty_o=1, overflow_o=0, and nothing was written.
   - Asserting rst_n=0 asynchronously at level 3: outputs return to reset values immediately.

Source files
------------

// File: rtl/imt_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imt_fifo_pkg
//  Description : Shared FIFO helpers. Provides the level-width function, the
//                status struct used by FIFO wrappers, and the async-reset
//                enabled flop macro used for FIFO storage registers.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================

// Enabled flop with asynchronous active-low reset.
`ifndef IMT_FFARNE
`define IMT_FFARNE(q, d, en, rst_val, clk, rst_n) \
  always_ff @(posedge clk or negedge rst_n) begin \
    if (!rst_n) q <= (rst_val); \
    else if (en) q <= (d); \
  end
`endif

package imt_fifo_pkg;

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wrap_ptr
//  Description : Modulo-DEPTH pointer. Counts 0..DEPTH-1 and wraps to 0,
//                correct for any DEPTH (not only powers of two).
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                clr_i  - synchronous clear to 0 (priority over inc_i)
//                inc_i  - advance by one
//                ptr_o  - current pointer value
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  localparam int PtrWidth = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  localparam logic [PtrWidth-1:0] c_last = PtrWidth'(DEPTH - 1);

  logic [PtrWidth-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      // Explicit wrap: natural binary rollover only works for 2**n depths.
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + PtrWidth'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_level.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_level
//  Description : Synchronous FIFO with arbitrary depth, optional first-word
//                fall-through, push-while-full-with-pop, fill level,
//                programmable almost-full/empty flags and sticky
//                overflow/underflow flags.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                flush_i             - clear pointers, level and error flags
//                push_i, data_i      - write request and data
//                pop_i, data_o       - read request and head entry
//                full_o, empty_o     - level == DEPTH / level == 0
//                level_o             - stored entry count
//                af_thresh_i         - almost_full_o  = level >= threshold
//                ae_thresh_i         - almost_empty_o = level <= threshold
//                clr_err_i           - clear sticky error flags
//                overflow_o          - sticky: a push was refused
//                underflow_o         - sticky: a pop was refused
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_level
  import imt_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH   = 64,
  parameter int  DEPTH        = 8,
  parameter bit  FALL_THROUGH = 1'b0,
  parameter type data_t       = logic [DATA_WIDTH-1:0],
  localparam int CntWidth     = cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                push_i,
  input  data_t               data_i,
  input  logic                pop_i,
  output data_t               data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] level_o,
  input  logic [CntWidth-1:0] af_thresh_i,
  input  logic [CntWidth-1:0] ae_thresh_i,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  input  logic                clr_err_i,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int PtrWidth = $clog2(DEPTH);
  localparam logic [CntWidth-1:0] c_depth = CntWidth'(DEPTH);

  data_t               r_mem [DEPTH];
  logic [CntWidth-1:0] r_level;
  logic                r_overflow;
  logic                r_underflow;

  logic [PtrWidth-1:0] w_rd_ptr;
  logic [PtrWidth-1:0] w_wr_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_bypass;
  logic                w_push_acc;
  logic                w_pop_acc;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_push_err;
  logic                w_pop_err;
  fifo_status_t        w_status;

  // --------------------------------------------------------------------------
  // Accept logic
  // --------------------------------------------------------------------------
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == c_depth);

  // Fall-through bypass: the word goes straight from data_i to the consumer,
  // so neither pointer moves and the level is untouched.
  assign w_bypass   = FALL_THROUGH && w_empty && push_i && pop_i;

  // A pop in the same cycle frees the head slot, so a full FIFO may accept.
  assign w_push_acc = push_i && !flush_i && (!w_full || pop_i);
  assign w_pop_acc  = pop_i  && !flush_i && (!w_empty || w_bypass);

  assign w_wr_en    = w_push_acc && !w_bypass;
  assign w_rd_en    = w_pop_acc  && !w_bypass;

  // Flush drops the request silently, so it never counts as refused.
  assign w_push_err = push_i && !w_push_acc && !flush_i;
  assign w_pop_err  = pop_i  && !w_pop_acc  && !flush_i;

  // --------------------------------------------------------------------------
  // Pointers
  // --------------------------------------------------------------------------
  fifo_wrap_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (w_wr_en),
    .ptr_o (w_wr_ptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (w_rd_en),
    .ptr_o (w_rd_ptr)
  );

  // --------------------------------------------------------------------------
  // Storage. When full with a pop, wr_ptr equals rd_ptr, so the new word
  // overwrites the slot being read out this cycle.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      logic w_sel;
      assign w_sel = w_wr_en && (w_wr_ptr == PtrWidth'(i));
      `IMT_FFARNE(r_mem[i], data_i, w_sel, '0, clk, rst_n)
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (flush_i) begin
      r_level <= '0;
    end else begin
      r_level <= r_level + CntWidth'(w_wr_en) - CntWidth'(w_rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i || clr_err_i) begin
      // Clear wins over a coincident set.
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  || w_push_err;
      r_underflow <= r_underflow || w_pop_err;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    data_o = '0;
    if (!w_empty) begin
      data_o = r_mem[w_rd_ptr];
    end else if (FALL_THROUGH && push_i) begin
      data_o = data_i;
    end
  end

  // Thresholds at 0 / >= DEPTH force the flags high through the plain compare.
  always_comb begin
    w_status              = '0;
    w_status.full         = w_full;
    w_status.empty        = w_empty;
    w_status.almost_full  = (r_level >= af_thresh_i);
    w_status.almost_empty = (r_level <= ae_thresh_i);
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  assign full_o         = w_status.full;
  assign empty_o        = w_status.empty;
  assign almost_full_o  = w_status.almost_full;
  assign almost_empty_o = w_status.almost_empty;
  assign overflow_o     = w_status.overflow;
  assign underflow_o    = w_status.underflow;
  assign level_o        = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_level.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_level
//  Description : Self-checking bench for fifo_level. Three instances share
//                one stimulus stream: (0) DEPTH=5 registered, (1) DEPTH=5
//                fall-through, (2) DEPTH=8 registered. A queue-style model
//                predicts every output each cycle; directed sections pin the
//                model with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_level;

  localparam int DW = 16;
  localparam int DEP [3] = '{5, 5, 8};
  localparam int FT  [3] = '{0, 1, 0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [3:0]    afv [3];
  logic [3:0]    aev [3];

  logic [DW-1:0] dout [3];
  logic          full [3];
  logic          empty [3];
  logic          afo [3];
  logic          aeo [3];
  logic          ovo [3];
  logic          uno [3];
  logic [2:0]    lvl_a;
  logic [2:0]    lvl_b;
  logic [3:0]    lvl_c;

  int errors = 0;
  int checks = 0;

  // Behavioural model: per instance, an ordered list of stored words.
  logic [DW-1:0] mdat [3][8];
  int            mcnt [3];
  bit            mov  [3];
  bit            mun  [3];

  fifo_level #(.DATA_WIDTH(DW), .DEPTH(5), .FALL_THROUGH(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .push_i(push), .data_i(din),
    .pop_i(pop), .data_o(dout[0]), .full_o(full[0]), .empty_o(empty[0]),
    .level_o(lvl_a), .af_thresh_i(afv[0][2:0]), .ae_thresh_i(aev[0][2:0]),
    .almost_full_o(afo[0]), .almost_empty_o(aeo[0]), .clr_err_i(clr),
    .overflow_o(ovo[0]), .underflow_o(uno[0]));

  fifo_level #(.DATA_WIDTH(DW), .DEPTH(5), .FALL_THROUGH(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .push_i(push), .data_i(din),
    .pop_i(pop), .data_o(dout[1]), .full_o(full[1]), .empty_o(empty[1]),
    .level_o(lvl_b), .af_thresh_i(afv[1][2:0]), .ae_thresh_i(aev[1][2:0]),
    .almost_full_o(afo[1]), .almost_empty_o(aeo[1]), .clr_err_i(clr),
    .overflow_o(ovo[1]), .underflow_o(uno[1]));

  fifo_level #(.DATA_WIDTH(DW), .DEPTH(8), .FALL_THROUGH(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .push_i(push), .data_i(din),
    .pop_i(pop), .data_o(dout[2]), .full_o(full[2]), .empty_o(empty[2]),
    .level_o(lvl_c), .af_thresh_i(afv[2]), .ae_thresh_i(aev[2]),
    .almost_full_o(afo[2]), .almost_empty_o(aeo[2]), .clr_err_i(clr),
    .overflow_o(ovo[2]), .underflow_o(uno[2]));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int k);
    if (k == 0) return int'(lvl_a);
    if (k == 1) return int'(lvl_b);
    return int'(lvl_c);
  endfunction

  function automatic int thr(input logic [3:0] v, input int k);
    return (k == 2) ? int'(v) : int'(v[2:0]);
  endfunction

  function automatic int exp_data(input int k);
    if (mcnt[k] > 0) return int'(mdat[k][0]);
    if (FT[k] == 1 && push) return int'(din);
    return 0;
  endfunction

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mcnt[k] = 0; mov[k] = 0; mun[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (flush) begin
          mcnt[k] = 0; mov[k] = 0; mun[k] = 0;
        end else begin
          if (!(FT[k] == 1 && mcnt[k] == 0 && push && pop)) begin
            if (pop && mcnt[k] == 0) mun[k] = 1;
            if (push && mcnt[k] == DEP[k] && !pop) mov[k] = 1;
            if (pop && mcnt[k] > 0) begin
              for (int j = 0; j < 7; j++) mdat[k][j] = mdat[k][j+1];
              mcnt[k]--;
            end
            if (push && (mcnt[k] < DEP[k])) begin
              mdat[k][mcnt[k]] = din;
              mcnt[k]++;
            end
          end
          if (clr) begin
            mov[k] = 0; mun[k] = 0;
          end
        end
      end
    end
  end

  // Single compare process: every output of every instance, every cycle.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d.level", k), lvl_of(k), mcnt[k]);
      chk($sformatf("dut%0d.data", k), int'(dout[k]), exp_data(k));
      chk($sformatf("dut%0d.full", k), int'(full[k]), int'(mcnt[k] == DEP[k]));
      chk($sformatf("dut%0d.empty", k), int'(empty[k]), int'(mcnt[k] == 0));
      chk($sformatf("dut%0d.afull", k), int'(afo[k]), int'(mcnt[k] >= thr(afv[k], k)));
      chk($sformatf("dut%0d.aempty", k), int'(aeo[k]), int'(mcnt[k] <= thr(aev[k], k)));
      chk($sformatf("dut%0d.ovf", k), int'(ovo[k]), int'(mov[k]));
      chk($sformatf("dut%0d.unf", k), int'(uno[k]), int'(mun[k]));
    end
  end

  task automatic tick(input bit pu, input bit po, input logic [DW-1:0] d,
                      input bit fl, input bit cl);
    push = pu; pop = po; din = d; flush = fl; clr = cl;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; clr = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      afv[k] = 4'd3; aev[k] = 4'd1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("reset.empty", int'(empty[0]), 1);
    chk("reset.full", int'(full[0]), 0);
    chk("reset.level", int'(lvl_a), 0);
    chk("reset.data", int'(dout[0]), 0);
    chk("reset.ovf", int'(ovo[0]), 0);
    chk("reset.unf", int'(uno[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill DEPTH=5 and push once more.
    for (int i = 1; i <= 5; i++) tick(1, 0, DW'(i * 16'h11), 0, 0);
    tick(1, 0, 16'h66, 0, 0);
    chk("t1.full", int'(full[0]), 1);
    chk("t1.level", int'(lvl_a), 5);
    chk("t1.ovf", int'(ovo[0]), 1);
    for (int i = 1; i <= 5; i++) begin
      chk("t1.pop_data", int'(dout[0]), i * 16'h11);
      tick(0, 1, 0, 0, 0);
    end
    chk("t1.empty", int'(empty[0]), 1);

    // Wrap-around at constant level 2.
    tick(0, 0, 0, 1, 0);
    tick(1, 0, 16'hA0, 0, 0);
    tick(1, 0, 16'hA1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      chk("t2.data", int'(dout[0]), 16'hA0 + i);
      chk("t2.level", int'(lvl_a), 2);
      tick(1, 1, DW'(16'hA2 + i), 0, 0);
    end

    // Full plus simultaneous push and pop.
    tick(0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) tick(1, 0, DW'(i), 0, 0);
    chk("t3.head", int'(dout[0]), 1);
    tick(1, 1, 16'd6, 0, 0);
    chk("t3.head2", int'(dout[0]), 2);
    chk("t3.full", int'(full[0]), 1);
    chk("t3.ovf", int'(ovo[0]), 0);
    for (int i = 2; i <= 6; i++) begin
      chk("t3.pop_data", int'(dout[0]), i);
      tick(0, 1, 0, 0, 0);
    end

    // Fall-through on empty.
    tick(0, 0, 0, 1, 0);
    push = 1; din = 16'hAB; #1;
    chk("t4.ft_data", int'(dout[1]), 16'hAB);
    pop = 1; #1;
    chk("t4.ft_data_pop", int'(dout[1]), 16'hAB);
    tick(1, 1, 16'hAB, 0, 0);
    chk("t4.level", int'(lvl_b), 0);
    chk("t4.unf0", int'(uno[1]), 0);
    tick(0, 1, 0, 0, 0);
    chk("t4.unf1", int'(uno[1]), 1);
    tick(0, 0, 0, 0, 1);
    chk("t4.clr", int'(uno[1]), 0);

    // Thresholds on DEPTH=8.
    tick(0, 0, 0, 1, 0);
    afv[2] = 4'd6; aev[2] = 4'd2;
    for (int lv = 0; lv <= 8; lv++) begin
      #1;
      chk("t5.level", int'(lvl_c), lv);
      chk("t5.aempty", int'(aeo[2]), int'(lv <= 2));
      chk("t5.afull", int'(afo[2]), int'(lv >= 6));
      if (lv < 8) tick(1, 0, DW'(lv), 0, 0);
    end
    aev[2] = 4'd8; #1;
    chk("t5.ae_ge_depth", int'(aeo[2]), 1);
    tick(0, 0, 0, 1, 0);
    afv[2] = 4'd0; #1;
    chk("t5.af_zero", int'(afo[2]), 1);
    afv[2] = 4'd6; aev[2] = 4'd2;

    // Flush at level 4 with overflow set, then async reset at level 3.
    tick(0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) tick(1, 0, DW'(i), 0, 0);
    tick(1, 0, 16'h99, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("t6.level4", int'(lvl_a), 4);
    chk("t6.ovf_set", int'(ovo[0]), 1);
    tick(1, 0, 16'h77, 1, 0);
    chk("t6.fl_level", int'(lvl_a), 0);
    chk("t6.fl_empty", int'(empty[0]), 1);
    chk("t6.fl_ovf", int'(ovo[0]), 0);
    chk("t6.fl_data", int'(dout[0]), 0);
    for (int i = 1; i <= 3; i++) tick(1, 0, DW'(16'h30 + i), 0, 0);
    chk("t6.level3", int'(lvl_a), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_level", int'(lvl_a), 0);
    chk("t6.rst_empty", int'(empty[0]), 1);
    chk("t6.rst_data", int'(dout[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with drifting push/pop bias.
    for (int i = 0; i < 1200; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 70 : 35;
      if (i % 50 == 0) begin
        afv[0] = 4'($urandom_range(0, 6)); aev[0] = 4'($urandom_range(0, 6));
        afv[1] = 4'($urandom_range(0, 6)); aev[1] = 4'($urandom_range(0, 6));
        afv[2] = 4'($urandom_range(0, 9)); aev[2] = 4'($urandom_range(0, 9));
      end
      tick($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (105 - bias),
           DW'($urandom), $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
